// File: rtl/arb_requester_pkg.sv
// Shared channel constants and grant-decode helpers for the arbiter requester front end.
package arb_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef logic [CH_W-1:0]   ch_idx_t;
  typedef logic [NUM_CH-1:0] ch_vec_t;

  function automatic ch_idx_t onehot_to_idx(input ch_vec_t oh);
    ch_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) begin
        idx = idx | ch_idx_t'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input ch_vec_t v);
    return (v != ch_vec_t'(0)) && ((v & (v - ch_vec_t'(1))) == ch_vec_t'(0));
  endfunction

  // Isolates the least-significant set bit (two's-complement trick).
  function automatic ch_vec_t lowest_set(input ch_vec_t v);
    return v & (~v + ch_vec_t'(1));
  endfunction

endpackage

// File: rtl/arb_requester_req_fifo.sv
// Per-channel request FIFO: registered count, wrapping pointers, head always visible on rdata.
module req_fifo
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == {CW{1'b0}});
  assign rdata     = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next-state pointers and occupancy; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = do_push_s ? (wr_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? (rd_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; cleared on reset so the head never presents stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Requester front end: per-channel FIFOs drive req, grants pop onto a shared registered bus.
// Build option ARB_REQ_ERR_CHECK_EN enables strict grant checking with a sticky err flag.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    in_valid,
  input  logic [NUM_CH*DW-1:0] in_data,
  output logic [NUM_CH-1:0]    in_ready,
  output logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH-1:0]    gnt,
  output logic                 out_valid,
  output logic [CH_W-1:0]      out_chan,
  output logic [DW-1:0]        out_data,
  output logic                 err
);

  logic [DW-1:0] head_s [NUM_CH];
  ch_vec_t       full_s;
  ch_vec_t       empty_s;
  ch_vec_t       pop_s;
  ch_vec_t       grant_oh_s;
  ch_idx_t       sel_idx_s;
  logic          valid_gnt_s;

  logic          out_valid_q, out_valid_d;
  ch_idx_t       out_chan_q, out_chan_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          err_q, err_d;

  assign in_ready = ~full_s;
  assign req      = ~empty_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid[g]),
      .pop   (pop_s[g]),
      .wdata (in_data[g*DW +: DW]),
      .rdata (head_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g])
    );
  end

`ifdef ARB_REQ_ERR_CHECK_EN
  logic invalid_gnt_s;

  // Strict grant check: must be one-hot and target a non-empty channel.
  always_comb begin
    grant_oh_s    = gnt;
    valid_gnt_s   = is_onehot(gnt) && ((gnt & ~empty_s) != ch_vec_t'(0));
    invalid_gnt_s = (gnt != ch_vec_t'(0)) && !valid_gnt_s;
  end

  assign err_d = err_q | invalid_gnt_s;
`else
  // Lenient grant: service the lowest-index granted channel that holds data.
  always_comb begin
    grant_oh_s  = lowest_set(gnt & ~empty_s);
    valid_gnt_s = (grant_oh_s != ch_vec_t'(0));
  end

  assign err_d = 1'b0;
`endif

  // Pop strobe and output-register next state.
  always_comb begin
    sel_idx_s = onehot_to_idx(grant_oh_s);
    if (valid_gnt_s) begin
      pop_s       = grant_oh_s;
      out_valid_d = 1'b1;
      out_chan_d  = sel_idx_s;
      out_data_d  = head_s[sel_idx_s];
    end else begin
      pop_s       = ch_vec_t'(0);
      out_valid_d = 1'b0;
      out_chan_d  = out_chan_q;
      out_data_d  = out_data_q;
    end
  end

  // Registered output bus and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= ch_idx_t'(0);
      out_data_q  <= {DW{1'b0}};
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
Requester-side front end for the 4-channel round-robin arbiter's req/gnt interface. It holds a small FIFO per client channel and drives req[3:0] from FIFO occupancy. On each one-hot gnt it pops the granted channel's head entry and presents it on a single shared output bus. It sits between four client producers and the arbiter plus the shared resource.

Parameters:
DW, 8, payload width per entry in bits
DEPTH, 4, entries per channel FIFO; power of 2, minimum 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  4  per-channel push strobe
in_data  input  4*DW  per-channel payload; channel i occupies bits [i*DW +: DW]
in_ready  output  4  per-channel not-full
req  output  4  request to arbiter; bit i = channel i FIFO non-empty
gnt  input  4  grant from arbiter; one-hot or zero, one-cycle pulse
out_valid  output  1  registered output strobe, one cycle per serviced grant
out_chan  output  2  channel index of out_data
out_data  output  DW  popped payload
err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync-release domain of clk): all FIFOs empty, count=0, pointers=0. Outputs: req=0, in_ready=4'b1111, out_valid=0, out_chan=0, out_data=0, err=0. Reset mid-operation discards all queued entries; no out_valid is emitted for them.
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Per-channel FIFO: registered count of width $clog2(DEPTH)+1. Wr/rd pointers wrap modulo DEPTH.
- in_ready[i] = (count[i] != DEPTH); it is decoded from registered state, never from in_valid or gnt.
- Push: in_valid[i] && in_ready[i] writes in_data slice at the tail. A push while full is dropped silently; count stays unchanged.
- req[i] = (count[i] != 0). It is decoded from a register, so it is glitch-free. req stays high until the entry is popped.
- Valid grant: gnt is exactly one-hot, bit i set, and count[i] != 0.
  - Pop head of channel i in that cycle.
  - Next cycle: out_valid=1, out_chan=i, out_data=head entry. Latency is 1 clk from gnt.
- out_valid drops to 0 in any cycle not following a valid grant. out_chan and out_data hold their last value.
- Simultaneous push and pop on the same channel in the same cycle:
  - count is unchanged.
  - The pop returns the old head.
  - in_ready is computed pre-update, so a full FIFO still rejects the push that cycle.
- Pop leaving count=0 deasserts req[i] the next cycle. This is in time for the arbiter, which samples req once per 4-cycle round.
- gnt=0: no action.
- Invalid grant, either of:
  - gnt not one-hot
  - gnt one-hot to an empty channel
  Response: no pop, no out_valid, err set to 1 next cycle. err stays 1 until reset.
- There is no back-pressure on the output bus. The consumer must accept every out_valid.

Optional Feature:
ARB_REQ_ERR_CHECK_EN
- Defined: invalid-grant detection as above, with a sticky err flag.
- Undefined:
  - err is tied to 0.
  - A multi-hot gnt services the lowest-index bit whose channel is non-empty.
  - A grant to an empty channel is ignored silently.

Decomposition:
- Package arb_pkg: NUM_CH=4, CH_W=2, typedef ch_idx_t (logic [CH_W-1:0]), function onehot_to_idx.
- One sub-module, req_fifo: parameterised by DW and DEPTH, with ports clk, rst_n, push, pop, wdata, rdata, full, empty. It is instantiated NUM_CH times in a generate loop.
- arb_requester top contains grant validation, the one-hot decode, the output register and err.

Test Plan:
1. Reset, then push ch0 0xA5 -> req=4'b0001 next cycle. gnt=4'b0001 pulse -> out_valid=1, out_chan=0, out_data=0xA5 one cycle later; then req=0.
2. Fill ch2 with 0x10,0x11,0x12,0x13 (DEPTH=4) -> in_ready[2]=0. A fifth push of 0x14 is dropped. Four gnt=4'b0100 pulses -> out_data 0x10..0x13 in order, then req[2]=0.
3. ch1 full, same-cycle push 0x55 and gnt=4'b0010 -> pop returns old head, push rejected, count stays 3 after pop.
4. Hook to the round-robin arbiter with all four channels loaded (one entry each: 0x01,0x02,0x04,0x08) -> out_chan sequence 0,1,2,3, one out_valid per 4-cycle round, req ends 0.
5. With ARB_REQ_ERR_CHECK_EN: gnt=4'b0011 -> no out_valid, err=1 next cycle and held. gnt=4'b1000 with ch3 empty -> err stays 1. rst_n low -> err=0.
6. Assert rst_n low with ch0 holding 2 entries during a gnt pulse -> no out_valid afterwards, req=0, in_ready=4'b1111.
